rr_arbiter_n: RTL and testbench

- N-requester arbiter with a registered one-hot grant.
- Parametrised successor to the team's fixed three-device arbiter.
- Adds a selectable fixed-priority or round-robin search order.
- Adds an optional hold limit that preempts a long-held grant when other requesters are waiting.
- Sits between N bus masters and a shared resource. Masters hold req high for as long as they need the resource.

---
 rtl/rr_arbiter_n.sv | 107 ++++++++++
 tb/tb_rr_arbiter_n.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_n.sv
// N-way arbiter with a registered one-hot grant, fixed-priority or round-robin search,
// and an optional hold limit that preempts a long-held grant when others are waiting.
module rr_arbiter_n #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;
  logic [7:0]     hold_q, hold_d;

  logic [N-1:0]   search_req;
  logic           owner_req;
  logic           other_req;
  logic           preempt;
  logic           search_en;
  logic           hit;
  logic [IDW-1:0] pick;

  // The current owner never competes in its own re-search; while idle grant_q is zero.
  assign search_req = req & ~grant_q;
  assign owner_req  = |(req & grant_q);
  assign other_req  = |search_req;
  assign preempt    = (MAX_HOLD != 0) && valid_q && owner_req && other_req &&
                      (hold_q == 8'(MAX_HOLD - 1));
  assign search_en  = !valid_q || !owner_req || preempt;

  always_comb begin
    logic [IDW-1:0] idx;
    hit  = 1'b0;
    pick = '0;
    idx  = '0;
    if (!mode) begin
      // Descending scan so the lowest matching index is the final assignment.
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (search_req[IDW'(i)]) begin
          hit  = 1'b1;
          pick = IDW'(i);
        end
      end
    end else begin
      // Scan last+N down to last+1 so the first index after last wins; last itself is k=N.
      for (int k = int'(N); k >= 1; k--) begin
        idx = IDW'((int'(last_q) + k) % int'(N));
        if (search_req[idx]) begin
          hit  = 1'b1;
          pick = idx;
        end
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    valid_d = valid_q;
    id_d    = id_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if (search_en) begin
      hold_d = 8'd0;
      if (hit) begin
        grant_d       = '0;
        grant_d[pick] = 1'b1;
        valid_d       = 1'b1;
        id_d          = pick;
        last_d        = pick;
      end else begin
        grant_d = '0;
        valid_d = 1'b0;
      end
    end else if (hold_q != 8'd255) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      last_q  <= IDW'(N - 1);
      hold_q  <= 8'd0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: one instance without preemption, one with MAX_HOLD=4.
module tb_rr_arbiter_n;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic       valid_a, valid_b;
  logic [1:0] id_a, id_b;

  int n_checks;
  int n_pass;

  rr_arbiter_n #(.N(4), .MAX_HOLD(0)) u_h0 (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .req        (req_a),
    .grant      (grant_a),
    .grant_valid(valid_a),
    .grant_id   (id_a)
  );

  rr_arbiter_n #(.N(4), .MAX_HOLD(4)) u_h4 (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .req        (req_b),
    .grant      (grant_b),
    .grant_valid(valid_b),
    .grant_id   (id_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    mode  = 1'b1;
    req_a = 4'b0000;
    req_b = 4'b0000;
    #3;
    n_checks++;
    if (grant_a !== 4'b0000 || valid_a !== 1'b0 || id_a !== 2'd0)
      $display("FAIL reset_h0: grant=%b valid=%b id=%0d, want 0000/0/0", grant_a, valid_a, id_a);
    else n_pass++;
    n_checks++;
    if (grant_b !== 4'b0000 || valid_b !== 1'b0 || id_b !== 2'd0)
      $display("FAIL reset_h4: grant=%b valid=%b id=%0d, want 0000/0/0", grant_b, valid_b, id_b);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    step();
    n_checks++;
    if (valid_a !== 1'b0)
      $display("FAIL idle_after_reset: valid=%b, want 0", valid_a);
    else n_pass++;
  endtask

  task automatic test_sticky();
    req_a = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (grant_a !== 4'b0001 || id_a !== 2'd0 || valid_a !== 1'b1)
        $display("FAIL sticky[%0d]: grant=%b id=%0d valid=%b, want 0001/0/1",
                 c, grant_a, id_a, valid_a);
      else n_pass++;
    end
  endtask

  task automatic test_rotate();
    logic [3:0] req_v [4];
    logic [3:0] exp_g [4];
    logic [1:0] exp_i [4];
    req_v = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_i = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int s = 0; s < 4; s++) begin
      req_a = req_v[s];
      step();
      n_checks++;
      if (grant_a !== exp_g[s] || id_a !== exp_i[s] || valid_a !== 1'b1)
        $display("FAIL rotate[%0d]: grant=%b id=%0d valid=%b, want %b/%0d/1",
                 s, grant_a, id_a, valid_a, exp_g[s], exp_i[s]);
      else n_pass++;
    end
  endtask

  task automatic test_preempt();
    logic [3:0] exp_g [12];
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
              4'b0001, 4'b0001, 4'b0001, 4'b0001};
    req_b = 4'b0011;
    for (int s = 0; s < 12; s++) begin
      step();
      n_checks++;
      if (grant_b !== exp_g[s])
        $display("FAIL preempt[%0d]: grant=%b, want %b", s, grant_b, exp_g[s]);
      else n_pass++;
    end
  endtask

  task automatic test_no_preempt();
    int bad;
    bad   = 0;
    req_b = 4'b0100;
    step();
    for (int s = 0; s < 20; s++) begin
      step();
      if (grant_b !== 4'b0100 || id_b !== 2'd2) bad++;
    end
    n_checks++;
    if (bad != 0)
      $display("FAIL lone_hold: %0d bad cycles, last grant=%b id=%0d, want 0100/2",
               bad, grant_b, id_b);
    else n_pass++;
  endtask

  task automatic own_two_then_drop(input logic m, input logic [3:0] exp_g,
                                   input logic [1:0] exp_i, input string tag);
    mode  = 1'b1;
    req_a = 4'b0100;
    step();
    req_a = 4'b1111;
    step();
    n_checks++;
    if (grant_a !== 4'b0100)
      $display("FAIL %s_setup: grant=%b, want 0100", tag, grant_a);
    else n_pass++;
    mode  = m;
    req_a = 4'b1011;
    step();
    n_checks++;
    if (grant_a !== exp_g || id_a !== exp_i || valid_a !== 1'b1)
      $display("FAIL %s: grant=%b id=%0d, want %b/%0d", tag, grant_a, id_a, exp_g, exp_i);
    else n_pass++;
  endtask

  task automatic test_mode_order();
    own_two_then_drop(1'b0, 4'b0001, 2'd0, "fixed_next");
    own_two_then_drop(1'b1, 4'b1000, 2'd3, "rr_next");
  endtask

  task automatic test_async_reset();
    mode  = 1'b1;
    req_a = 4'b0100;
    step();
    n_checks++;
    if (grant_a !== 4'b0100)
      $display("FAIL areset_setup: grant=%b, want 0100", grant_a);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (grant_a !== 4'b0000 || valid_a !== 1'b0 || id_a !== 2'd0)
      $display("FAIL areset_clear: grant=%b valid=%b id=%0d, want 0000/0/0",
               grant_a, valid_a, id_a);
    else n_pass++;
    req_a = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    step();
    n_checks++;
    if (grant_a !== 4'b0001 || id_a !== 2'd0 || valid_a !== 1'b1)
      $display("FAIL areset_restart: grant=%b id=%0d, want 0001/0", grant_a, id_a);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_sticky();
    test_rotate();
    test_preempt();
    test_no_preempt();
    test_mode_order();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
